// File: rtl/zoom_pkg.sv
// ---------------------------------------------------------------
// zoom_pkg : shared widths and defaults for the HDMI zoom path
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package zoom_pkg;
  localparam int IMG_W_DEF = 1920;
  localparam int IMG_H_DEF = 1080;
  localparam int PIX_CW    = 8;
  localparam int PIX_W     = 3 * PIX_CW;
  localparam int OUT_CW    = 10;
endpackage

`default_nettype wire

// File: rtl/avg4_u8.sv
// ---------------------------------------------------------------
// avg4_u8 : two-stage rounded mean of four 8-bit values
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module avg4_u8
  import zoom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [PIX_CW-1:0] p11,
  input  logic [PIX_CW-1:0] p12,
  input  logic [PIX_CW-1:0] p21,
  input  logic [PIX_CW-1:0] p22,
  output logic              s1_vld,
  output logic              s2_vld,
  output logic [PIX_CW-1:0] out_pix
);

  logic [PIX_CW:0] r_a;
  logic [PIX_CW:0] r_b;

  // Stage-1 sums carry no reset; only the valid bit matters.
  always_ff @(posedge clk) begin
    if (in_vld) begin
      r_a <= {1'b0, p11} + {1'b0, p12};
      r_b <= {1'b0, p21} + {1'b0, p22};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      out_pix <= '0;
    end else begin
      s1_vld <= in_vld & ~clr;
      s2_vld <= s1_vld & ~clr;
      if (s1_vld && !clr) begin
        out_pix <= PIX_CW'(({2'b00, r_a} + {2'b00, r_b} + 11'd2) >> 2);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/zoom_avg2x2_hdmi.sv
// ---------------------------------------------------------------
// zoom_avg2x2_hdmi : 2x2 box-filter downscaler with output coordinates
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module zoom_avg2x2_hdmi
  import zoom_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_clr,
  input  logic              win_vld,
  input  logic [PIX_W-1:0]  win11,
  input  logic [PIX_W-1:0]  win12,
  input  logic [PIX_W-1:0]  win21,
  input  logic [PIX_W-1:0]  win22,
  input  logic              win_x,
  input  logic              win_y,
  output logic              pix_vld,
  output logic [PIX_W-1:0]  pix_data,
  output logic [OUT_CW-1:0] pix_x,
  output logic [OUT_CW-1:0] pix_y,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              frame_done
);

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam logic [OUT_CW-1:0] C_LAST_COL = OUT_CW'(OUT_W - 1);
  localparam logic [OUT_CW-1:0] C_LAST_ROW = OUT_CW'(OUT_H - 1);

  logic              w_take;
  logic [2:0]        w_s1_vld;
  logic [2:0]        w_s2_vld;
  logic              w_s1_any;
  logic              w_last_col;
  logic              w_last_row;
  logic [OUT_CW-1:0] r_col;
  logic [OUT_CW-1:0] r_row;

  // A clear in the same cycle as a take drops that window.
  assign w_take = win_vld & win_x & win_y & ~frame_clr;

  generate
    for (genvar c = 0; c < 3; c++) begin : g_ch
      avg4_u8 u_avg (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_clr),
        .in_vld  (w_take),
        .p11     (win11[c*PIX_CW +: PIX_CW]),
        .p12     (win12[c*PIX_CW +: PIX_CW]),
        .p21     (win21[c*PIX_CW +: PIX_CW]),
        .p22     (win22[c*PIX_CW +: PIX_CW]),
        .s1_vld  (w_s1_vld[c]),
        .s2_vld  (w_s2_vld[c]),
        .out_pix (pix_data[c*PIX_CW +: PIX_CW])
      );
    end
  endgenerate

  // The three channel valid pipelines are identical; reduce them to one.
  assign w_s1_any   = &w_s1_vld;
  assign pix_vld    = &w_s2_vld;
  assign w_last_col = (r_col == C_LAST_COL);
  assign w_last_row = (r_row == C_LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sol    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else if (frame_clr) begin
      r_col      <= '0;
      r_row      <= '0;
      pix_sol    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else if (w_s1_any) begin
      pix_x      <= r_col;
      pix_y      <= r_row;
      pix_sol    <= (r_col == '0);
      pix_eol    <= w_last_col;
      frame_done <= w_last_col & w_last_row;
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + OUT_CW'(1);
      end else begin
        r_col <= r_col + OUT_CW'(1);
      end
    end else begin
      pix_sol    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

`default_nettype wire
